// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: 2-FF sync, start-glitch reject, mid-bit sampling, stop check.
// rx_done ~9.5 bit periods + 3 clocks after start edge; no backpressure, one-cycle strobes.
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       led
);

  localparam int BAUD_MCNT = CLK_FREQ / BAUD - 1;
  localparam int HALF_MCNT = BAUD_MCNT / 2;
  localparam int CW        = $clog2(BAUD_MCNT + 1);
  localparam logic [CW-1:0] BAUD_MAX = CW'(BAUD_MCNT);
  localparam logic [CW-1:0] HALF_PT  = CW'(HALF_MCNT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_reg_q, shift_reg_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_done_q, rx_done_d;
  logic          frame_err_q, frame_err_d;
  logic          led_q, led_d;

  logic          fall;
  logic          sample;
  logic          bit_end;
  logic [CW-1:0] baud_inc;

  assign fall     = rx_s3_q & ~rx_s2_q;
  assign sample   = (baud_cnt_q == HALF_PT);
  assign bit_end  = (baud_cnt_q == BAUD_MAX);
  assign baud_inc = bit_end ? '0 : baud_cnt_q + CW'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      // Synchroniser resets to the idle-line level so reset never looks like a start bit.
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      state_q     <= ST_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_reg_q <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      rx_s1_q     <= uart_rx;
      rx_s2_q     <= rx_s1_q;
      rx_s3_q     <= rx_s2_q;
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_reg_q <= shift_reg_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      led_q       <= led_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_reg_d = shift_reg_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    led_d       = led_q;

    unique case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        if (fall) begin
          state_d    = ST_START;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      ST_START: begin
        baud_cnt_d = baud_inc;
        if (sample && rx_s2_q) begin
          state_d    = ST_IDLE;
          baud_cnt_d = '0;
        end else if (bit_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        baud_cnt_d = baud_inc;
        if (sample) begin
          shift_reg_d = {rx_s2_q, shift_reg_q[7:1]};
          bit_cnt_d   = bit_cnt_q + 4'd1;
        end
        if (bit_end && (bit_cnt_q == 4'd8)) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        baud_cnt_d = baud_inc;
        // Leaving at mid-stop gives half a bit of slack to catch a back-to-back start edge.
        if (sample) begin
          baud_cnt_d = '0;
          if (rx_s2_q) begin
            rx_data_d = shift_reg_q;
            rx_done_d = 1'b1;
            led_d     = ~led_q;
            state_d   = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        baud_cnt_d = '0;
        if (rx_s2_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign led       = led_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: frames driven bit-by-bit, expected bytes scoreboarded.
module tb_uart_byte_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int BIT      = CLK_FREQ / BAUD;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       led;

  logic       drv_line;
  logic       tx_line;
  logic       loop_en;
  logic       tx_busy;
  logic [7:0] tx_b;

  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] last_good;
  int         checks;
  int         errors;
  int         done_cnt;
  int         ferr_cnt;
  logic       prev_done;
  logic       prev_ferr;

  assign uart_rx = loop_en ? tx_line : drv_line;

  uart_byte_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .led      (led)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Stand-in transmitter for loopback: serialises queued bytes as 8N1.
  initial begin
    tx_line = 1'b1;
    tx_busy = 1'b0;
    forever begin
      @(posedge sys_clk);
      if (tx_q.size() > 0) begin
        tx_b    = tx_q.pop_front();
        tx_busy = 1'b1;
        tx_line = 1'b0;
        repeat (BIT) @(posedge sys_clk);
        for (int i = 0; i < 8; i++) begin
          tx_line = tx_b[i];
          repeat (BIT) @(posedge sys_clk);
        end
        tx_line = 1'b1;
        repeat (BIT) @(posedge sys_clk);
        tx_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every rx_done pops one expected byte.
  initial begin
    prev_done = 1'b0;
    prev_ferr = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (rx_done || frame_err) begin
        checks++;
        if (rx_done && frame_err) begin
          errors++;
          $display("FAIL strobe_exclusive: rx_done=%0b frame_err=%0b, required not both", rx_done, frame_err);
        end
        checks++;
        if ((rx_done && prev_done) || (frame_err && prev_ferr)) begin
          errors++;
          $display("FAIL strobe_width: strobe high 2 cycles, required 1");
        end
      end
      if (rx_done) begin
        done_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rx_done: rx_data=%h, required no strobe", rx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            errors++;
            $display("FAIL rx_data: got %h, required %h", rx_data, e);
          end
        end
      end
      if (frame_err) ferr_cnt++;
      prev_done = rx_done;
      prev_ferr = frame_err;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drv_line = 1'b0;
    repeat (BIT) @(posedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      drv_line = b[i];
      repeat (BIT) @(posedge sys_clk);
    end
    drv_line = stop_bit;
    repeat (BIT) @(posedge sys_clk);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
    last_good = b;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic pulse_reset();
    @(posedge sys_clk);
    sys_rst_n = 1'b0;
    drv_line  = 1'b1;
    repeat (3) @(posedge sys_clk);
    sys_rst_n = 1'b1;
    settle(2 * BIT);
    last_good = 8'h00;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    drv_line  = 1'b1;
    loop_en   = 1'b0;
    repeat (4) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h, required 00", rx_data); end
    checks++;
    if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done: got %b, required 0", rx_done); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    checks++;
    if (led !== 1'b0) begin errors++; $display("FAIL reset_led: got %b, required 0", led); end
    sys_rst_n = 1'b1;
    settle(2 * BIT);
  endtask

  task automatic test_single();
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    expect_byte(8'h55);
    send_byte(8'h55, 1'b1);
    settle(BIT);
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_count: got %0d, required 1", done_cnt - d0); end
    checks++;
    if (ferr_cnt != f0) begin errors++; $display("FAIL single_frame_err: got %0d, required 0", ferr_cnt - f0); end
    checks++;
    if (led !== 1'b1) begin errors++; $display("FAIL single_led: got %b, required 1", led); end
    checks++;
    if (rx_data !== 8'h55) begin errors++; $display("FAIL single_hold: got %h, required 55", rx_data); end
  endtask

  task automatic test_back_to_back();
    int d0;
    pulse_reset();
    d0 = done_cnt;
    expect_byte(8'h0F);
    send_byte(8'h0F, 1'b1);
    checks++;
    if (led !== 1'b1) begin errors++; $display("FAIL b2b_led_mid: got %b, required 1", led); end
    expect_byte(8'hF0);
    send_byte(8'hF0, 1'b1);
    settle(BIT);
    checks++;
    if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_count: got %0d, required 2", done_cnt - d0); end
    checks++;
    if (led !== 1'b0) begin errors++; $display("FAIL b2b_led: got %b, required 0", led); end
    checks++;
    if (rx_data !== 8'hF0) begin errors++; $display("FAIL b2b_hold: got %h, required F0", rx_data); end
  endtask

  task automatic test_glitch();
    int d0, f0;
    d0 = done_cnt; f0 = ferr_cnt;
    drv_line = 1'b0;
    repeat (BIT / 4) @(posedge sys_clk);
    drv_line = 1'b1;
    settle(3 * BIT);
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL glitch_done: got %0d, required 0", done_cnt - d0); end
    checks++;
    if (ferr_cnt != f0) begin errors++; $display("FAIL glitch_frame_err: got %0d, required 0", ferr_cnt - f0); end
    expect_byte(8'h5A);
    send_byte(8'h5A, 1'b1);
    settle(BIT);
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL glitch_recover: got %0d, required 1", done_cnt - d0); end
  endtask

  task automatic test_frame_error();
    int d0, f0;
    logic [7:0] keep;
    keep = last_good;
    d0 = done_cnt; f0 = ferr_cnt;
    send_byte(8'hA5, 1'b0);
    drv_line = 1'b0;
    repeat (30 * BIT) @(posedge sys_clk);
    drv_line = 1'b1;
    settle(2 * BIT);
    checks++;
    if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_count: got %0d, required 1", ferr_cnt - f0); end
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL ferr_done: got %0d, required 0", done_cnt - d0); end
    checks++;
    if (rx_data !== keep) begin errors++; $display("FAIL ferr_hold: got %h, required %h", rx_data, keep); end
    expect_byte(8'h3C);
    send_byte(8'h3C, 1'b1);
    settle(BIT);
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL ferr_recover: got %0d, required 1", done_cnt - d0); end
  endtask

  task automatic test_reset_midframe();
    int d0;
    logic [7:0] b;
    b = 8'h81;
    d0 = done_cnt;
    drv_line = 1'b0;
    repeat (BIT) @(posedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      drv_line = b[i];
      repeat (BIT) @(posedge sys_clk);
    end
    drv_line = b[4];
    repeat (BIT / 2) @(posedge sys_clk);
    sys_rst_n = 1'b0;
    drv_line  = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_rx_data: got %h, required 00", rx_data); end
    checks++;
    if (led !== 1'b0) begin errors++; $display("FAIL midrst_led: got %b, required 0", led); end
    repeat (3) @(posedge sys_clk);
    sys_rst_n = 1'b1;
    settle(12 * BIT);
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL midrst_done: got %0d, required 0", done_cnt - d0); end
    expect_byte(8'h81);
    send_byte(8'h81, 1'b1);
    settle(BIT);
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL midrst_recover: got %0d, required 1", done_cnt - d0); end
    checks++;
    if (rx_data !== 8'h81) begin errors++; $display("FAIL midrst_hold: got %h, required 81", rx_data); end
  endtask

  task automatic test_loopback();
    int d0;
    int budget;
    d0 = done_cnt;
    loop_en = 1'b1;
    expect_byte(8'h0F);
    tx_q.push_back(8'h0F);
    expect_byte(8'hF0);
    tx_q.push_back(8'hF0);
    repeat (2) @(posedge sys_clk);
    budget = 0;
    while ((tx_busy || tx_q.size() > 0) && budget < 40 * BIT) begin
      @(posedge sys_clk);
      budget++;
    end
    checks++;
    if (budget >= 40 * BIT) begin errors++; $display("FAIL loop_timeout: waited %0d cycles, required tx idle", budget); end
    settle(BIT);
    checks++;
    if (done_cnt - d0 != 2) begin errors++; $display("FAIL loop_done_count: got %0d, required 2", done_cnt - d0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL loop_leftover: got %0d pending, required 0", exp_q.size()); end
    loop_en = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    done_cnt  = 0;
    ferr_cnt  = 0;
    last_good = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
